// File: rtl/nf10_axis_memcached_pkg.sv
// Shared types and helpers for the memcached stream transmitter.
//   state_t     : FSM encoding (IDLE, STREAM, FIN)
//   beat_t      : one output beat {tdata, last, strb} held in the prefetch FIFO
//   last_strb   : TSTRB of the final beat from the byte-length residue
//   ceil_words  : number of 64-bit words covering a byte length
package nf10_axis_memcached_pkg;

  localparam int unsigned BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [7:0]  strb;
  } beat_t;

  // Residue 0 means the last word is full.
  function automatic logic [7:0] last_strb(input logic [2:0] res);
    logic [8:0] mask;
    mask = (9'd1 << res) - 9'd1;
    return (res == 3'd0) ? 8'hFF : mask[7:0];
  endfunction

  function automatic int unsigned ceil_words(input int unsigned len);
    return (len + BEAT_BYTES - 1) / BEAT_BYTES;
  endfunction

endpackage

// File: rtl/nf10_axis_memcached_txfifo2.sv
// Two-entry fall-through FIFO of output beats. Entry 0 is always the head,
// so the head is driven straight from a register.
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : write strobe and beat (never asserted when full)
//   pop           : read strobe (never asserted when empty)
//   head, count   : current head entry and occupancy (0..2)
module nf10_axis_memcached_txfifo2
  import nf10_axis_memcached_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      din,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t      e0, e1;
  logic [1:0] cnt;

  // Shift-register storage: a pop moves entry 1 down into entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = e0;
  assign count = cnt;

endmodule

// File: rtl/nf10_axis_memcached_streamtx.sv
// Transmit-side reader of the memcached 64-bit stream buffer. A start command
// reads ceil(len/8) words from address 0 upward and emits them as an
// AXI4-Stream packet, prefetching through a 2-entry FIFO to hide the buffer's
// one-cycle read latency.
//   ACLK, ARESET            : clock, synchronous active-high reset
//   start_*                 : start command (len in bytes, sideband tuser)
//   busy, done              : packet in progress / one-cycle completion pulse
//   rd64_addr, rd64_data    : buffer read port (data one clock after address)
//   M_AXIS_*                : 64-bit AXI4-Stream master
module nf10_axis_memcached_streamtx
  import nf10_axis_memcached_pkg::*;
#(
  parameter int unsigned WC_MAX      = 190,
  parameter int unsigned WC_WIDTH    = 8,
  parameter int unsigned LEN_WIDTH   = 11,
  parameter int unsigned TUSER_WIDTH = 128
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [LEN_WIDTH-1:0]   start_len,
  input  logic [TUSER_WIDTH-1:0] start_tuser,
  output logic                   busy,
  output logic                   done,
  output logic [WC_WIDTH-1:0]    rd64_addr,
  input  logic [63:0]            rd64_data,
  output logic [63:0]            M_AXIS_TDATA,
  output logic [7:0]             M_AXIS_TSTRB,
  output logic [TUSER_WIDTH-1:0] M_AXIS_TUSER,
  output logic                   M_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY
);

  localparam int unsigned CNT_W     = WC_WIDTH + 1;
  localparam int unsigned MAX_BYTES = WC_MAX * BEAT_BYTES;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       rd_ptr, words;
  logic [2:0]             res_q;
  logic [TUSER_WIDTH-1:0] tuser_q;
  logic                   inflight, inflight_last;
  logic [WC_WIDTH-1:0]    addr_q;
  logic                   done_q;

  logic [LEN_WIDTH-1:0]   len_clamped;
  logic                   start_fire, tvalid, pop, issue, issue_last;
  logic [2:0]             occ;
  beat_t                  push_beat, head;
  logic [1:0]             fifo_cnt;

  assign start_fire  = (state == ST_IDLE) && start_valid;
  assign len_clamped = (32'(start_len) > MAX_BYTES) ? LEN_WIDTH'(MAX_BYTES) : start_len;

  assign tvalid = (fifo_cnt != 2'd0);
  assign pop    = tvalid && M_AXIS_TREADY;

  // Occupancy counts the slot freed by this cycle's pop, which is what lets
  // the stream sustain one beat per clock with a read always in flight.
  assign occ        = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
  assign issue      = (state == ST_STREAM) && (rd_ptr < words) && (occ < 3'd2);
  assign issue_last = (rd_ptr == words - CNT_W'(1));
  assign rd64_addr  = issue ? WC_WIDTH'(rd_ptr) : addr_q;

  // Data returned this cycle belongs to the read issued last cycle.
  always_comb begin
    push_beat.data = rd64_data;
    push_beat.last = inflight_last;
    push_beat.strb = inflight_last ? last_strb(res_q) : 8'hFF;
  end

  nf10_axis_memcached_txfifo2 u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (inflight),
    .din   (push_beat),
    .pop   (pop),
    .head  (head),
    .count (fifo_cnt)
  );

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start_valid) state_nxt = (start_len == '0) ? ST_FIN : ST_STREAM;
      ST_STREAM: if (pop && head.last) state_nxt = ST_FIN;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM and stream outputs.
  always_comb begin
    start_ready   = (state == ST_IDLE);
    busy          = (state != ST_IDLE);
    done          = done_q;
    M_AXIS_TVALID = tvalid;
    M_AXIS_TDATA  = head.data;
    M_AXIS_TLAST  = tvalid && head.last;
    M_AXIS_TSTRB  = tvalid ? head.strb : 8'h00;
    M_AXIS_TUSER  = tuser_q;
  end

  // Command latch, read pointer and in-flight tracking.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_ptr        <= '0;
      words         <= '0;
      res_q         <= 3'd0;
      tuser_q       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      addr_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= (state == ST_FIN);
      inflight      <= issue;
      inflight_last <= issue && issue_last;
      if (issue) begin
        addr_q <= WC_WIDTH'(rd_ptr);
        rd_ptr <= rd_ptr + CNT_W'(1);
      end
      if (start_fire) begin
        words   <= CNT_W'(ceil_words(32'(len_clamped)));
        res_q   <= len_clamped[2:0];
        tuser_q <= start_tuser;
        rd_ptr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nf10_axis_memcached_streamtx.sv
module tb_nf10_axis_memcached_streamtx;

  logic         clk = 1'b0;
  logic         areset;
  logic         start_valid;
  logic         start_ready;
  logic [10:0]  start_len;
  logic [127:0] start_tuser;
  logic         busy, done;
  logic [7:0]   rd64_addr;
  logic [63:0]  rd64_data;
  logic [63:0]  tdata;
  logic [7:0]   tstrb;
  logic [127:0] tuser;
  logic         tlast, tvalid, tready;

  logic [63:0]  mem [256];

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  strb;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Buffer model: synchronous read, data valid one clock after the address.
  always @(posedge clk) rd64_data <= mem[rd64_addr];

  nf10_axis_memcached_streamtx dut (
    .ACLK          (clk),
    .ARESET        (areset),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .start_len     (start_len),
    .start_tuser   (start_tuser),
    .busy          (busy),
    .done          (done),
    .rd64_addr     (rd64_addr),
    .rd64_data     (rd64_data),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TUSER  (tuser),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One packet: rmode 0 keeps TREADY high, 1 toggles it pseudo-randomly.
  // abort_after >= 0 asserts ARESET once that many beats have been accepted.
  task automatic run_packet(input int len, input int rmode, input int abort_after);
    int lc, w, res, n, beats, budget, first_seen, done_cnt;
    logic [7:0]   last_strb_e;
    logic [127:0] tu;
    logic         finished, stalled, tv, tr;
    logic [63:0]  held_d;
    logic         held_l;
    logic [7:0]   held_s;
    exp_t         e;

    lc  = (len > 1520) ? 1520 : len;
    w   = (lc + 7) / 8;
    res = lc % 8;
    last_strb_e = (res == 0) ? 8'hFF : 8'((1 << res) - 1);
    tu = {$urandom, $urandom, $urandom, $urandom};
    sb.delete();
    for (int i = 0; i < w; i++) begin
      e.data = mem[i];
      e.last = (i == w - 1);
      e.strb = (i == w - 1) ? last_strb_e : 8'hFF;
      sb.push_back(e);
    end

    start_valid = 1'b1;
    start_len   = 11'(len);
    start_tuser = tu;
    tready      = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
    check("start_ready_low", 128'(start_ready), 128'(0));
    if (w > 0) check("first_addr", 128'(rd64_addr), 128'(0));

    n = 0; beats = 0; finished = (w == 0); stalled = 1'b0;
    first_seen = 0; budget = 4 * w + 20;
    held_d = '0; held_l = 1'b0; held_s = '0;
    while (!finished && n < budget) begin
      if (abort_after >= 0 && beats == abort_after) break;
      tready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      tv = tvalid; tr = tready;
      if (tv && first_seen == 0) begin
        first_seen = 1;
        check("first_valid_cycle", 128'(n), 128'(2));
      end
      if (stalled) begin
        check("stall_valid", 128'(tv), 128'(1));
        check("stall_data", {tdata, held_d}, {held_d, held_d});
        check("stall_ctl", 128'({tlast, tstrb}), 128'({held_l, held_s}));
      end
      stalled = tv && !tr;
      held_d = tdata; held_l = tlast; held_s = tstrb;
      if (tv && tr) begin
        if (sb.size() == 0) begin
          check("extra_beat", 128'(beats), 128'(w));
        end else begin
          e = sb.pop_front();
          check("beat_data", 128'(tdata), 128'(e.data));
          check("beat_last", 128'(tlast), 128'(e.last));
          check("beat_strb", 128'(tstrb), 128'(e.strb));
          check("beat_tuser", tuser, tu);
          if (rmode == 0) check("back_to_back", 128'(n), 128'(2 + beats));
          if (e.last) finished = 1'b1;
        end
        beats++;
      end
      check("no_done_midpacket", 128'(done), 128'(0));
      @(posedge clk); #1;
      n++;
    end

    if (abort_after >= 0) begin
      areset = 1'b1;
      @(posedge clk); #1;
      check("abort_tvalid", 128'(tvalid), 128'(0));
      check("abort_idle", 128'({start_ready, busy, done}), 128'(3'b100));
      areset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (done || tvalid) done_cnt++;
      end
      check("abort_quiet", 128'(done_cnt), 128'(0));
      sb.delete();
      return;
    end

    if (!finished) check("timeout", 128'(0), 128'(1));
    check("beat_count", 128'(beats), 128'(w));
    check("fin_state", 128'({busy, done}), 128'(2'b10));
    @(posedge clk); #1;
    check("done_pulse", 128'({done, busy, start_ready, tvalid}), 128'(4'b1010));
    @(posedge clk); #1;
    check("done_cleared", 128'(done), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i), 32'(i) * 32'h9E3779B9};
    mem[0] = 64'h1111111111111111;
    mem[1] = 64'h2222222222222222;
    areset = 1'b1; start_valid = 1'b0; start_len = '0; start_tuser = '0; tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", 128'({start_ready, busy, done, tvalid, tlast}), 128'(5'b10000));
    check("rst_tstrb", 128'(tstrb), 128'(0));
    check("rst_tdata", 128'(tdata), 128'(0));
    check("rst_tuser", tuser, 128'(0));
    check("rst_addr", 128'(rd64_addr), 128'(0));
    areset = 1'b0;
    @(posedge clk); #1;

    run_packet(16, 0, -1);
    run_packet(13, 0, -1);
    run_packet(1, 0, -1);
    run_packet(0, 0, -1);
    run_packet(1520, 1, -1);
    run_packet(2000, 0, -1);
    run_packet(2000, 1, -1);
    run_packet(80, 0, 3);
    run_packet(8, 0, -1);
    run_packet(37, 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
